state_sequencer: RTL

Multi-cycle instruction phase sequencer for the datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Phases are skipped according to the instruction class, and a memory phase waits on a ready handshake bounded by a timeout. From the registered phase it drives the register-write, memory-access, memory-write and fetch strobes, and it reports completion and timeout status to the top-level controller.

---
 rtl/state_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/state_sequencer.sv
// Instruction phase sequencer: steps FETCH/DECODE/EXEC/MEM/WB with class-based
// phase skipping, a bounded MEM ready wait, and strobes decoded from the phase register.
module state_sequencer #(
   parameter int MEM_TIMEOUT = 8,
   parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Start,
   input  logic [1:0] Op_Class,
   input  logic       Stall,
   input  logic       Mem_Ready,
   output logic [2:0] State,
   output logic       State_Reg_Write,
   output logic       State_Memory,
   output logic       State_Mem_Write,
   output logic       Fetch_En,
   output logic       Busy,
   output logic       Done,
   output logic       Timeout_Err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } phase_t;

   typedef enum logic [1:0] {
      CLS_ALU    = 2'b00,
      CLS_LOAD   = 2'b01,
      CLS_STORE  = 2'b10,
      CLS_BRANCH = 2'b11
   } op_class_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   phase_t           phase;
   op_class_t        cls;
   logic [CNT_W-1:0] mem_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= IDLE;
         cls         <= CLS_ALU;
         mem_cnt     <= '0;
         Done        <= 1'b0;
         Timeout_Err <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (phase)
            IDLE: begin
               if (Start) begin
                  phase       <= FETCH;
                  cls         <= op_class_t'(Op_Class);
                  mem_cnt     <= '0;
                  Timeout_Err <= 1'b0;
               end
            end
            FETCH:  if (!Stall) phase <= DECODE;
            DECODE: if (!Stall) phase <= EXEC;
            EXEC: begin
               if (!Stall) begin
                  case (cls)
                     CLS_ALU:   phase <= WB;
                     CLS_LOAD,
                     CLS_STORE: begin
                        phase   <= MEM;
                        mem_cnt <= '0;
                     end
                     default: begin
                        phase <= IDLE;
                        Done  <= 1'b1;
                     end
                  endcase
               end
            end
            MEM: begin
               // Ready is tested first so it wins over an expiring wait.
               if (Mem_Ready) begin
                  if (cls == CLS_LOAD) begin
                     phase <= WB;
                  end else begin
                     phase <= IDLE;
                     Done  <= 1'b1;
                  end
               end else if (mem_cnt == CNT_LAST) begin
                  phase       <= IDLE;
                  Timeout_Err <= 1'b1;
               end else begin
                  mem_cnt <= mem_cnt + CNT_W'(1);
               end
            end
            WB: begin
               if (!Stall) begin
                  phase <= IDLE;
                  Done  <= 1'b1;
               end
            end
            default: phase <= IDLE;
         endcase
      end
   end

   always_comb begin
      State           = phase;
      State_Reg_Write = (phase == WB);
      State_Memory    = (phase == MEM);
      State_Mem_Write = (phase == MEM) && (cls == CLS_STORE);
      Fetch_En        = (phase == FETCH);
      Busy            = (phase != IDLE);
   end

endmodule
